// File: rtl/sram_arbiter_ctrl_pkg.sv
// Shared types for the two-port 16-bit SRAM controller: FSM states, port ids,
// the latched request record and the first-beat selection helper.
package sram_arbiter_ctrl_pkg;

    localparam int SRAM_ADDR_W_DFLT = 18;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        RSP  = 2'd3
    } sram_state_e;

    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } sram_port_e;

    typedef struct packed {
        logic                          we;
        logic [SRAM_ADDR_W_DFLT-2:0]   addr;
        logic [31:0]                   wdata;
        logic [3:0]                    strb;
    } sram_req_t;

    // Writes with an empty half skip that beat; reads always start low.
    function automatic sram_state_e sram_first_beat(input sram_req_t req);
        sram_state_e st;
        if (!req.we || (req.strb[1:0] != 2'b00)) begin
            st = LO;
        end else if (req.strb[3:2] != 2'b00) begin
            st = HI;
        end else begin
            st = RSP;
        end
        return st;
    endfunction

endpackage

// File: rtl/sram_arbiter_ctrl_rr_arbiter.sv
// Two-way round-robin arbiter between the instruction and data ports.
// grant[0] = instruction port, grant[1] = data port.
module sram_rr_arbiter
    import sram_arbiter_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        ireq,
    input  logic        dreq,
    input  logic        en,
    output logic [1:0]  grant,
    output sram_port_e  ptr
);

    logic [1:0] grant_s;
    sram_port_e ptr_r;

    // Grant decode: contention resolved by the pointer, a lone requester always wins.
    always_comb begin
        grant_s = 2'b00;
        if (en) begin
            if (ireq && dreq) begin
                grant_s = (ptr_r == PORT_D) ? 2'b10 : 2'b01;
            end else if (ireq) begin
                grant_s = 2'b01;
            end else if (dreq) begin
                grant_s = 2'b10;
            end else begin
                grant_s = 2'b00;
            end
        end else begin
            grant_s = 2'b00;
        end
    end

    // Pointer moves to favour the port that just lost its turn.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r <= PORT_D;
        end else if (grant_s[1]) begin
            ptr_r <= PORT_I;
        end else if (grant_s[0]) begin
            ptr_r <= PORT_D;
        end else begin
            ptr_r <= ptr_r;
        end
    end

    assign grant = grant_s;
    assign ptr   = ptr_r;

endmodule

// File: rtl/sram_arbiter_ctrl.sv
// Shares one external 16-bit SRAM between I-cache refill and D-cache/LSU ports;
// each 32-bit access is sequenced as a low then a high half-word beat.
module sram_arbiter_ctrl
    import sram_arbiter_ctrl_pkg::*;
#(
    parameter int ACCESS_CYC  = 2,
    parameter int SRAM_ADDR_W = SRAM_ADDR_W_DFLT
)
(
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_ireq_vld,
    input  logic [31:0]             i_ireq_addr,
    output logic                    o_ireq_rdy,
    output logic                    o_irsp_vld,
    output logic [31:0]             o_irsp_data,
    input  logic                    i_dreq_vld,
    input  logic                    i_dreq_we,
    input  logic [31:0]             i_dreq_addr,
    input  logic [31:0]             i_dreq_wdata,
    input  logic [3:0]              i_dreq_strb,
    output logic                    o_dreq_rdy,
    output logic                    o_drsp_vld,
    output logic [31:0]             o_drsp_data,
    output logic [SRAM_ADDR_W-1:0]  SRAM_ADDR,
    inout  wire  [15:0]             SRAM_DQ,
    output logic                    SRAM_CE_N,
    output logic                    SRAM_WE_N,
    output logic                    SRAM_OE_N,
    output logic                    SRAM_LB_N,
    output logic                    SRAM_UB_N
);

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_LO    = LO;
    localparam logic [1:0] ST_HI    = HI;
    localparam logic [1:0] ST_RSP   = RSP;
    localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYC - 1);

    logic [1:0]             state_r, state_nx_s;
    logic [3:0]             cnt_r, cnt_nx_s;
    sram_req_t              req_r, req_nx_s, ireq_s, dreq_s;
    sram_port_e             port_r, port_nx_s, ptr_s;
    logic [31:0]            data_r, data_nx_s;
    logic [1:0]             grant_s;
    logic                   accept_s, beat_nx_s, hi_nx_s;

    logic [SRAM_ADDR_W-1:0] sram_addr_r, sram_addr_nx_s;
    logic                   ce_n_r, we_n_r, oe_n_r, lb_n_r, ub_n_r, dq_oe_r;
    logic                   ce_n_nx_s, we_n_nx_s, oe_n_nx_s, lb_n_nx_s, ub_n_nx_s, dq_oe_nx_s;
    logic [15:0]            dq_out_r, dq_out_nx_s;
    logic                   irsp_vld_r, drsp_vld_r, irsp_go_s, drsp_go_s;
    logic [31:0]            irsp_data_r, drsp_data_r;
    logic                   unused_s;

    sram_rr_arbiter u_arb (
        .clk   (i_clk),
        .rst   (i_rst),
        .ireq  (i_ireq_vld),
        .dreq  (i_dreq_vld),
        .en    ((state_r == ST_IDLE) && !i_rst),
        .grant (grant_s),
        .ptr   (ptr_s)
    );

    assign accept_s   = |grant_s;
    assign o_ireq_rdy = grant_s[0];
    assign o_dreq_rdy = grant_s[1];

    // Request records as they would be latched from each port.
    always_comb begin
        ireq_s       = '0;
        ireq_s.we    = 1'b0;
        ireq_s.addr  = i_ireq_addr[SRAM_ADDR_W:2];
        dreq_s       = '0;
        dreq_s.we    = i_dreq_we;
        dreq_s.addr  = i_dreq_addr[SRAM_ADDR_W:2];
        dreq_s.wdata = i_dreq_wdata;
        dreq_s.strb  = i_dreq_strb;
    end

    // Beat sequencing; read data is captured on the last cycle of each beat.
    always_comb begin
        state_nx_s = state_r;
        cnt_nx_s   = cnt_r;
        req_nx_s   = req_r;
        port_nx_s  = port_r;
        data_nx_s  = data_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    req_nx_s   = grant_s[1] ? dreq_s : ireq_s;
                    port_nx_s  = grant_s[1] ? PORT_D : PORT_I;
                    data_nx_s  = 32'h0000_0000;
                    state_nx_s = sram_first_beat(req_nx_s);
                    cnt_nx_s   = CNT_LOAD;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_LO: begin
                if (cnt_r == 4'd0) begin
                    if (!req_r.we) begin
                        data_nx_s[15:0] = SRAM_DQ;
                    end else begin
                        data_nx_s = data_r;
                    end
                    if (!req_r.we || (req_r.strb[3:2] != 2'b00)) begin
                        state_nx_s = ST_HI;
                        cnt_nx_s   = CNT_LOAD;
                    end else begin
                        state_nx_s = ST_RSP;
                    end
                end else begin
                    cnt_nx_s = cnt_r - 4'd1;
                end
            end
            ST_HI: begin
                if (cnt_r == 4'd0) begin
                    if (!req_r.we) begin
                        data_nx_s[31:16] = SRAM_DQ;
                    end else begin
                        data_nx_s = data_r;
                    end
                    state_nx_s = ST_RSP;
                end else begin
                    cnt_nx_s = cnt_r - 4'd1;
                end
            end
            ST_RSP: begin
                state_nx_s = ST_IDLE;
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    assign beat_nx_s = (state_nx_s == ST_LO) || (state_nx_s == ST_HI);
    assign hi_nx_s   = (state_nx_s == ST_HI);

    // SRAM pin values for the coming cycle, registered so the pins never glitch.
    always_comb begin
        sram_addr_nx_s = '0;
        ce_n_nx_s      = 1'b1;
        we_n_nx_s      = 1'b1;
        oe_n_nx_s      = 1'b1;
        lb_n_nx_s      = 1'b1;
        ub_n_nx_s      = 1'b1;
        dq_oe_nx_s     = 1'b0;
        dq_out_nx_s    = 16'h0000;
        if (beat_nx_s) begin
            sram_addr_nx_s = {req_nx_s.addr, hi_nx_s};
            ce_n_nx_s      = 1'b0;
            if (req_nx_s.we) begin
                // Last beat cycle holds address/data with WE_N released.
                we_n_nx_s   = (cnt_nx_s == 4'd0);
                oe_n_nx_s   = 1'b1;
                lb_n_nx_s   = hi_nx_s ? ~req_nx_s.strb[2] : ~req_nx_s.strb[0];
                ub_n_nx_s   = hi_nx_s ? ~req_nx_s.strb[3] : ~req_nx_s.strb[1];
                dq_oe_nx_s  = 1'b1;
                dq_out_nx_s = hi_nx_s ? req_nx_s.wdata[31:16] : req_nx_s.wdata[15:0];
            end else begin
                we_n_nx_s   = 1'b1;
                oe_n_nx_s   = 1'b0;
                lb_n_nx_s   = 1'b0;
                ub_n_nx_s   = 1'b0;
                dq_oe_nx_s  = 1'b0;
                dq_out_nx_s = 16'h0000;
            end
        end else begin
            sram_addr_nx_s = '0;
            ce_n_nx_s      = 1'b1;
        end
    end

    assign irsp_go_s = (state_nx_s == ST_RSP) && (port_nx_s == PORT_I);
    assign drsp_go_s = (state_nx_s == ST_RSP) && (port_nx_s == PORT_D);

    // State, request, pins and response registers; reset aborts without a response.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 4'd0;
            req_r       <= '0;
            port_r      <= PORT_D;
            data_r      <= 32'h0000_0000;
            sram_addr_r <= '0;
            ce_n_r      <= 1'b1;
            we_n_r      <= 1'b1;
            oe_n_r      <= 1'b1;
            lb_n_r      <= 1'b1;
            ub_n_r      <= 1'b1;
            dq_oe_r     <= 1'b0;
            dq_out_r    <= 16'h0000;
            irsp_vld_r  <= 1'b0;
            irsp_data_r <= 32'h0000_0000;
            drsp_vld_r  <= 1'b0;
            drsp_data_r <= 32'h0000_0000;
        end else begin
            state_r     <= state_nx_s;
            cnt_r       <= cnt_nx_s;
            req_r       <= req_nx_s;
            port_r      <= port_nx_s;
            data_r      <= data_nx_s;
            sram_addr_r <= sram_addr_nx_s;
            ce_n_r      <= ce_n_nx_s;
            we_n_r      <= we_n_nx_s;
            oe_n_r      <= oe_n_nx_s;
            lb_n_r      <= lb_n_nx_s;
            ub_n_r      <= ub_n_nx_s;
            dq_oe_r     <= dq_oe_nx_s;
            dq_out_r    <= dq_out_nx_s;
            irsp_vld_r  <= irsp_go_s;
            irsp_data_r <= irsp_go_s ? data_nx_s : 32'h0000_0000;
            drsp_vld_r  <= drsp_go_s;
            drsp_data_r <= drsp_go_s ? data_nx_s : 32'h0000_0000;
        end
    end

    assign SRAM_ADDR   = sram_addr_r;
    assign SRAM_CE_N   = ce_n_r;
    assign SRAM_WE_N   = we_n_r;
    assign SRAM_OE_N   = oe_n_r;
    assign SRAM_LB_N   = lb_n_r;
    assign SRAM_UB_N   = ub_n_r;
    assign SRAM_DQ     = dq_oe_r ? dq_out_r : {16{1'bz}};
    assign o_irsp_vld  = irsp_vld_r;
    assign o_irsp_data = irsp_data_r;
    assign o_drsp_vld  = drsp_vld_r;
    assign o_drsp_data = drsp_data_r;

    assign unused_s = ^{i_ireq_addr[31:SRAM_ADDR_W+1], i_ireq_addr[1:0],
                        i_dreq_addr[31:SRAM_ADDR_W+1], i_dreq_addr[1:0], ptr_s};

endmodule

// File: tb/tb_sram_arbiter_ctrl.sv
// Directed bench for sram_arbiter_ctrl with a behavioural 16-bit SRAM model.
module tb_sram_arbiter_ctrl;

    logic        clk = 1'b0;
    logic        i_rst;
    logic        i_ireq_vld, o_ireq_rdy, o_irsp_vld;
    logic [31:0] i_ireq_addr, o_irsp_data;
    logic        i_dreq_vld, i_dreq_we, o_dreq_rdy, o_drsp_vld;
    logic [31:0] i_dreq_addr, i_dreq_wdata, o_drsp_data;
    logic [3:0]  i_dreq_strb;
    logic [17:0] SRAM_ADDR;
    wire  [15:0] SRAM_DQ;
    logic        SRAM_CE_N, SRAM_WE_N, SRAM_OE_N, SRAM_LB_N, SRAM_UB_N;

    always #5 clk = ~clk;

    sram_arbiter_ctrl #(.ACCESS_CYC(2), .SRAM_ADDR_W(18)) dut (
        .i_clk(clk), .i_rst(i_rst),
        .i_ireq_vld(i_ireq_vld), .i_ireq_addr(i_ireq_addr), .o_ireq_rdy(o_ireq_rdy),
        .o_irsp_vld(o_irsp_vld), .o_irsp_data(o_irsp_data),
        .i_dreq_vld(i_dreq_vld), .i_dreq_we(i_dreq_we), .i_dreq_addr(i_dreq_addr),
        .i_dreq_wdata(i_dreq_wdata), .i_dreq_strb(i_dreq_strb), .o_dreq_rdy(o_dreq_rdy),
        .o_drsp_vld(o_drsp_vld), .o_drsp_data(o_drsp_data),
        .SRAM_ADDR(SRAM_ADDR), .SRAM_DQ(SRAM_DQ), .SRAM_CE_N(SRAM_CE_N),
        .SRAM_WE_N(SRAM_WE_N), .SRAM_OE_N(SRAM_OE_N), .SRAM_LB_N(SRAM_LB_N),
        .SRAM_UB_N(SRAM_UB_N)
    );

    // SRAM model: asynchronous read, byte-lane writes while WE_N is low.
    logic [15:0] mem [0:1023];
    logic        model_drv;
    assign model_drv = !SRAM_CE_N && !SRAM_OE_N && SRAM_WE_N;
    assign SRAM_DQ   = model_drv ? mem[SRAM_ADDR[9:0]] : 16'hzzzz;

    always @(posedge clk) begin
        if (!SRAM_CE_N && !SRAM_WE_N) begin
            if (!SRAM_LB_N) mem[SRAM_ADDR[9:0]][7:0]  <= SRAM_DQ[7:0];
            if (!SRAM_UB_N) mem[SRAM_ADDR[9:0]][15:8] <= SRAM_DQ[15:8];
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
        end
    endtask

    logic [17:0] lg_addr [0:15];
    logic [15:0] lg_dq   [0:15];
    logic        lg_ce   [0:15];
    logic        lg_we   [0:15];
    logic        lg_oe   [0:15];
    logic        lg_lb   [0:15];
    logic        lg_ub   [0:15];
    int          lat;
    logic [31:0] rdata;

    // One transaction on one port; logs pins per cycle after the handshake (cycle 1..).
    task automatic run_txn(input bit dport, input bit we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] strb);
        bit got;
        if (dport) begin
            i_dreq_vld = 1'b1; i_dreq_we = we; i_dreq_addr = addr;
            i_dreq_wdata = wdata; i_dreq_strb = strb;
        end else begin
            i_ireq_vld = 1'b1; i_ireq_addr = addr;
        end
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (dport ? o_dreq_rdy : o_ireq_rdy) got = 1'b1;
            @(posedge clk); #1;
        end
        i_dreq_vld = 1'b0;
        i_ireq_vld = 1'b0;
        chk("handshake", {31'd0, got}, 32'd1);
        lat   = -1;
        rdata = 32'h0;
        for (int k = 1; k <= 14 && lat < 0; k++) begin
            @(negedge clk);
            lg_addr[k] = SRAM_ADDR; lg_dq[k] = SRAM_DQ; lg_ce[k] = SRAM_CE_N;
            lg_we[k] = SRAM_WE_N; lg_oe[k] = SRAM_OE_N; lg_lb[k] = SRAM_LB_N; lg_ub[k] = SRAM_UB_N;
            if (dport ? o_drsp_vld : o_irsp_vld) begin
                lat   = k;
                rdata = dport ? o_drsp_data : o_irsp_data;
            end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int gr [0:7];
        int gcyc [0:7];
        int ng, n_irsp, n_drsp, hang;
        bit got;

        i_rst = 1'b1;
        i_ireq_vld = 1'b0; i_ireq_addr = 32'h0;
        i_dreq_vld = 1'b0; i_dreq_we = 1'b0; i_dreq_addr = 32'h0;
        i_dreq_wdata = 32'h0; i_dreq_strb = 4'h0;
        for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
        mem[10'h040] = 16'h5678;
        mem[10'h041] = 16'h1234;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ctrl_pins", {27'd0, SRAM_CE_N, SRAM_WE_N, SRAM_OE_N, SRAM_LB_N, SRAM_UB_N}, 32'h1f);
        chk("rst_addr", {14'd0, SRAM_ADDR}, 32'h0);
        chk("rst_dq_z", {31'd0, SRAM_DQ === 16'hzzzz}, 32'd1);
        chk("rst_rsp_vld", {30'd0, o_irsp_vld, o_drsp_vld}, 32'h0);
        chk("rst_irsp_data", o_irsp_data, 32'h0);
        chk("rst_drsp_data", o_drsp_data, 32'h0);
        i_rst = 1'b0;
        @(posedge clk); #1;

        // Instruction read: hw 0x040/0x041
        run_txn(1'b0, 1'b0, 32'h0000_0080, 32'h0, 4'h0);
        chk("iread_lat", lat, 32'd5);
        chk("iread_data", rdata, 32'h1234_5678);
        chk("iread_addr_lo", {14'd0, lg_addr[1]}, 32'h040);
        chk("iread_addr_lo2", {14'd0, lg_addr[2]}, 32'h040);
        chk("iread_addr_hi", {14'd0, lg_addr[3]}, 32'h041);
        chk("iread_oe_ce", {28'd0, lg_oe[1], lg_oe[3], lg_ce[4], lg_ce[5]}, 32'b0001);
        chk("iread_we_lbub", {29'd0, lg_we[2], lg_lb[1], lg_ub[3]}, 32'b100);

        // Full data write
        run_txn(1'b1, 1'b1, 32'h0000_0008, 32'hDEAD_BEEF, 4'b1111);
        chk("dwr_lat", lat, 32'd5);
        chk("dwr_ack_data", rdata, 32'h0);
        chk("dwr_addr", {lg_addr[1][15:0], lg_addr[3][15:0]}, 32'h0004_0005);
        chk("dwr_dq", {lg_dq[1], lg_dq[3]}, 32'hBEEF_DEAD);
        chk("dwr_we_n", {28'd0, lg_we[1], lg_we[2], lg_we[3], lg_we[4]}, 32'b0101);
        chk("dwr_oe_n", {31'd0, lg_oe[1]}, 32'd1);
        chk("dwr_mem", {mem[10'h004], mem[10'h005]}, 32'hBEEF_DEAD);

        // High-half-only write, then read back
        run_txn(1'b1, 1'b1, 32'h0000_0008, 32'h00AB_0000, 4'b0100);
        chk("hwr_lat", lat, 32'd3);
        chk("hwr_addr", {14'd0, lg_addr[1]}, 32'h005);
        chk("hwr_lb_ub_ce", {29'd0, lg_lb[1], lg_ub[1], lg_ce[1]}, 32'b010);
        run_txn(1'b1, 1'b0, 32'h0000_0008, 32'h0, 4'h0);
        chk("rdback_lat", lat, 32'd5);
        chk("rdback_data", rdata, 32'hDEAB_BEEF);

        // Low-half-only write
        run_txn(1'b1, 1'b1, 32'h0000_0010, 32'h1111_2222, 4'b0011);
        chk("lwr_lat", lat, 32'd3);
        chk("lwr_addr", {14'd0, lg_addr[1]}, 32'h008);
        chk("lwr_mem", {mem[10'h008], mem[10'h009]}, 32'h2222_0000);

        // Zero-strobe write: ack only
        run_txn(1'b1, 1'b1, 32'h0000_0020, 32'h5555_5555, 4'b0000);
        chk("zwr_lat", lat, 32'd1);
        chk("zwr_ce_n", {31'd0, lg_ce[1]}, 32'd1);
        chk("zwr_ack_data", rdata, 32'h0);

        // Upper address bits ignored (wraps at 512 KiB)
        run_txn(1'b0, 1'b0, 32'hFFF8_0080, 32'h0, 4'h0);
        chk("wrap_data", rdata, 32'h1234_5678);
        chk("wrap_addr", {14'd0, lg_addr[1]}, 32'h040);

        // Contention from fresh reset: D,I,D,I,D,I with one idle cycle between
        i_rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        i_rst = 1'b0;
        i_ireq_vld = 1'b1; i_ireq_addr = 32'h0000_0080;
        i_dreq_vld = 1'b1; i_dreq_we = 1'b0; i_dreq_addr = 32'h0000_0008;
        ng = 0; n_irsp = 0; n_drsp = 0;
        for (int cyc = 0; cyc < 45; cyc++) begin
            @(negedge clk);
            if (o_ireq_rdy && o_dreq_rdy) chk("rr_both_rdy", 32'd1, 32'd0);
            if (ng < 8 && (o_ireq_rdy || o_dreq_rdy)) begin
                gr[ng]   = o_dreq_rdy ? 1 : 0;
                gcyc[ng] = cyc;
                ng++;
            end
            if (o_irsp_vld) begin n_irsp++; chk("rr_irsp_data", o_irsp_data, 32'h1234_5678); end
            if (o_drsp_vld) begin n_drsp++; chk("rr_drsp_data", o_drsp_data, 32'hDEAB_BEEF); end
            @(posedge clk); #1;
            if (ng >= 6) begin i_ireq_vld = 1'b0; i_dreq_vld = 1'b0; end
        end
        chk("rr_ngrant", ng, 32'd6);
        for (int k = 0; k < 6 && k < ng; k++) begin
            chk($sformatf("rr_grant%0d", k), gr[k], (k % 2 == 0) ? 32'd1 : 32'd0);
            if (k > 0) chk($sformatf("rr_gap%0d", k), gcyc[k] - gcyc[k-1], 32'd6);
        end
        chk("rr_rsp_counts", {n_irsp[15:0], n_drsp[15:0]}, 32'h0003_0003);

        // Reset during the high beat of a read
        i_ireq_vld = 1'b1; i_ireq_addr = 32'h0000_0080;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (o_ireq_rdy) got = 1'b1;
            @(posedge clk); #1;
        end
        i_ireq_vld = 1'b0;
        chk("abort_handshake", {31'd0, got}, 32'd1);
        repeat (3) @(negedge clk);
        chk("abort_hi_beat", {13'd0, SRAM_CE_N, SRAM_ADDR}, 32'h041);
        i_rst = 1'b1;
        @(posedge clk); #1;
        i_rst = 1'b0;
        chk("abort_ce_oe", {30'd0, SRAM_CE_N, SRAM_OE_N}, 32'b11);
        chk("abort_dq_z", {31'd0, SRAM_DQ === 16'hzzzz}, 32'd1);
        hang = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (o_irsp_vld || o_drsp_vld) hang++;
        end
        chk("abort_no_rsp", hang, 32'd0);
        @(posedge clk); #1;
        run_txn(1'b1, 1'b0, 32'h0000_0008, 32'h0, 4'h0);
        chk("post_abort_lat", lat, 32'd5);
        chk("post_abort_data", rdata, 32'hDEAB_BEEF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
